// File: rtl/ro_sample_sequencer.sv
// ============================================================================
// Module   : ro_sample_sequencer
// Purpose  : Sequences RO measurement windows and pushes one result per window
//            into the absorption FIFO, with backpressure and abort.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ro_sample_sequencer #(
    parameter int ADD_WIDTH        = 19,
    parameter int FIFO_WIDTH       = 20,
    parameter int COUNT_WIDTH      = 65,
    parameter int PIPELINE_LATENCY = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   go,
    input  logic                   stop,
    input  logic [COUNT_WIDTH-1:0] num_samples,
    input  logic [COUNT_WIDTH-1:0] collect_cycles,
    output logic                   ro_clear,
    output logic                   ro_en,
    input  logic [ADD_WIDTH-1:0]   sum_in,
    input  logic                   fifo_full,
    output logic                   fifo_wr_en,
    output logic [FIFO_WIDTH-1:0]  fifo_wr_data,
    output logic                   busy,
    output logic                   done,
    output logic [31:0]            stall_count
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_CLEAR     = 3'd1,
        S_COLLECT   = 3'd2,
        S_WAIT_PIPE = 3'd3,
        S_PUSH      = 3'd4,
        S_DONE      = 3'd5
    } state_t;

    localparam int              LAT_W    = (PIPELINE_LATENCY < 2) ? 1 : $clog2(PIPELINE_LATENCY + 1);
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(PIPELINE_LATENCY);

    state_t                  state_q;
    logic [COUNT_WIDTH-1:0]  ns_q;
    logic [COUNT_WIDTH-1:0]  cc_q;
    logic [COUNT_WIDTH-1:0]  win_q;
    logic [COUNT_WIDTH-1:0]  sample_q;
    logic [LAT_W-1:0]        lat_q;
    logic [31:0]             stall_q;

    logic [COUNT_WIDTH-1:0]  cc_d;
    logic [COUNT_WIDTH-1:0]  sample_d;
    logic [FIFO_WIDTH-1:0]   data_d;

    // A zero-length window is treated as one enable cycle.
    assign cc_d     = (collect_cycles == '0) ? COUNT_WIDTH'(1) : collect_cycles;
    assign sample_d = sample_q + COUNT_WIDTH'(1);

    generate
        if (ADD_WIDTH <= FIFO_WIDTH) begin : g_zext
            assign data_d = FIFO_WIDTH'(sum_in);
        end else begin : g_clamp
            localparam logic [ADD_WIDTH-1:0] MAX_VAL =
                {{(ADD_WIDTH-FIFO_WIDTH){1'b0}}, {FIFO_WIDTH{1'b1}}};
            assign data_d = (sum_in > MAX_VAL) ? {FIFO_WIDTH{1'b1}} : sum_in[FIFO_WIDTH-1:0];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            ns_q     <= '0;
            cc_q     <= '0;
            win_q    <= '0;
            sample_q <= '0;
            lat_q    <= '0;
            stall_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (go) begin
                        ns_q     <= num_samples;
                        cc_q     <= cc_d;
                        sample_q <= '0;
                        stall_q  <= '0;
                        state_q  <= (num_samples == '0) ? S_DONE : S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    if (stop) begin
                        state_q <= S_DONE;
                    end else begin
                        win_q   <= cc_q;
                        state_q <= S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    if (stop) begin
                        state_q <= S_DONE;
                    end else if (win_q <= COUNT_WIDTH'(1)) begin
                        lat_q   <= LAT_LOAD;
                        state_q <= (PIPELINE_LATENCY == 0) ? S_PUSH : S_WAIT_PIPE;
                    end else begin
                        win_q <= win_q - COUNT_WIDTH'(1);
                    end
                end
                S_WAIT_PIPE: begin
                    if (stop) begin
                        state_q <= S_DONE;
                    end else if (lat_q <= LAT_W'(1)) begin
                        state_q <= S_PUSH;
                    end else begin
                        lat_q <= lat_q - LAT_W'(1);
                    end
                end
                S_PUSH: begin
                    if (stop) begin
                        state_q <= S_DONE;
                    end else if (fifo_full) begin
                        if (stall_q != 32'hFFFF_FFFF) begin
                            stall_q <= stall_q + 32'd1;
                        end
                    end else begin
                        sample_q <= sample_d;
                        state_q  <= (sample_d == ns_q) ? S_DONE : S_CLEAR;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // stop gates the enables in the same cycle it is seen, ahead of the state change.
    assign ro_clear     = (state_q == S_CLEAR);
    assign ro_en        = (state_q == S_COLLECT) && !stop;
    assign fifo_wr_en   = (state_q == S_PUSH) && !fifo_full && !stop;
    assign fifo_wr_data = (state_q == S_PUSH) ? data_d : '0;
    assign busy         = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done         = (state_q == S_DONE);
    assign stall_count  = stall_q;

endmodule

`default_nettype wire

// File: tb/tb_ro_sample_sequencer.sv
// ============================================================================
// Module   : tb_ro_sample_sequencer
// Purpose  : Directed self-checking bench for ro_sample_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ro_sample_sequencer;

    localparam int CW = 65;

    logic          clk = 1'b0;
    logic          rst;
    logic          go, stop, fifo_full;
    logic [CW-1:0] num_samples, collect_cycles;
    logic [18:0]   sum_in;
    logic          ro_clear, ro_en, fifo_wr_en, busy, done;
    logic [19:0]   fifo_wr_data;
    logic [31:0]   stall_count;

    logic          go2, stop2, full2;
    logic [CW-1:0] ns2, cc2;
    logic [21:0]   sum2;
    logic          ro_clear2, ro_en2, wr_en2, busy2, done2;
    logic [19:0]   data2;
    logic [31:0]   stall2;

    int vectors    = 0;
    int miscompares = 0;

    int cyc = 0, wr_cnt = 0, en_cnt = 0, clr_cnt = 0, viol = 0;
    int          wr_cyc[$];
    logic [19:0] wr_dat[$];

    always #5 clk = ~clk;

    ro_sample_sequencer u_dut (
        .clk(clk), .rst(rst), .go(go), .stop(stop),
        .num_samples(num_samples), .collect_cycles(collect_cycles),
        .ro_clear(ro_clear), .ro_en(ro_en), .sum_in(sum_in), .fifo_full(fifo_full),
        .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
        .busy(busy), .done(done), .stall_count(stall_count)
    );

    ro_sample_sequencer #(.ADD_WIDTH(22), .FIFO_WIDTH(20)) u_dut_wide (
        .clk(clk), .rst(rst), .go(go2), .stop(stop2),
        .num_samples(ns2), .collect_cycles(cc2),
        .ro_clear(ro_clear2), .ro_en(ro_en2), .sum_in(sum2), .fifo_full(full2),
        .fifo_wr_en(wr_en2), .fifo_wr_data(data2),
        .busy(busy2), .done(done2), .stall_count(stall2)
    );

    always @(negedge clk) begin
        cyc++;
        if (fifo_wr_en) begin
            wr_cnt++;
            wr_cyc.push_back(cyc);
            wr_dat.push_back(fifo_wr_data);
            if (fifo_full) viol++;
        end
        if (ro_en) en_cnt++;
        if (ro_clear) clr_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic start(input logic [CW-1:0] ns, input logic [CW-1:0] cc);
        go = 1'b1; num_samples = ns; collect_cycles = cc;
        step();
        go = 1'b0;
    endtask

    task automatic wait_wr(input int target, input int budget);
        int k;
        k = 0;
        while (wr_cnt < target && k < budget) begin
            step();
            k++;
        end
        vectors++;
        if (wr_cnt < target) begin
            miscompares++;
            $display("FAIL wait_wr timeout: writes=%0d required=%0d", wr_cnt, target);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; go = 0; stop = 0; fifo_full = 0; sum_in = '0;
        num_samples = '0; collect_cycles = '0;
        go2 = 0; stop2 = 0; full2 = 0; ns2 = '0; cc2 = '0; sum2 = '0;
        steps(3);
        vectors++;
        if ({ro_clear, ro_en, fifo_wr_en, busy, done} !== 5'b0 || fifo_wr_data !== 20'h0 || stall_count !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: got ctl=%b data=%h stall=%0d required all zero",
                     {ro_clear, ro_en, fifo_wr_en, busy, done}, fifo_wr_data, stall_count);
        end
        rst = 1'b0;
        step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        step();
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL stop_in_idle: got done=%b busy=%b required 0 0", done, busy);
        end
    endtask

    task automatic test_basic();
        int base, be, bc;
        base = wr_cnt; be = en_cnt; bc = clr_cnt;
        sum_in = 19'h1234;
        start(4, 10);
        steps(5);
        go = 1'b1; num_samples = 9; collect_cycles = 2;
        step();
        go = 1'b0;
        wait_wr(base + 4, 120);
        vectors++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_done: got done=%b busy=%b required 1 0", done, busy);
        end
        steps(3);
        vectors++;
        if (wr_cnt - base !== 4) begin
            miscompares++;
            $display("FAIL basic_writes: got %0d required 4", wr_cnt - base);
        end
        vectors++;
        if (en_cnt - be !== 40) begin
            miscompares++;
            $display("FAIL basic_ro_en_cycles: got %0d required 40", en_cnt - be);
        end
        vectors++;
        if (clr_cnt - bc !== 4) begin
            miscompares++;
            $display("FAIL basic_ro_clear: got %0d required 4", clr_cnt - bc);
        end
        vectors++;
        if (done !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_done_held: got %b required 1", done);
        end
        for (int i = 0; i < 4 && base + i < wr_dat.size(); i++) begin
            vectors++;
            if (wr_dat[base+i] !== 20'h01234) begin
                miscompares++;
                $display("FAIL basic_data[%0d]: got %h required 01234", i, wr_dat[base+i]);
            end
            if (i > 0) begin
                vectors++;
                if (wr_cyc[base+i] - wr_cyc[base+i-1] !== 17) begin
                    miscompares++;
                    $display("FAIL basic_period[%0d]: got %0d required 17", i, wr_cyc[base+i] - wr_cyc[base+i-1]);
                end
            end
        end
    endtask

    task automatic test_zero_samples();
        int base, be, bc;
        base = wr_cnt; be = en_cnt; bc = clr_cnt;
        start(0, 5);
        vectors++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_done: got done=%b busy=%b required 1 0", done, busy);
        end
        steps(4);
        vectors++;
        if ((wr_cnt - base) + (en_cnt - be) + (clr_cnt - bc) !== 0) begin
            miscompares++;
            $display("FAIL zero_activity: got wr=%0d en=%0d clr=%0d required 0 0 0",
                     wr_cnt - base, en_cnt - be, clr_cnt - bc);
        end
    endtask

    task automatic test_cc_zero();
        int base, be;
        base = wr_cnt; be = en_cnt;
        start(2, 0);
        wait_wr(base + 2, 60);
        vectors++;
        if (en_cnt - be !== 2) begin
            miscompares++;
            $display("FAIL cc0_ro_en_cycles: got %0d required 2", en_cnt - be);
        end
        if (wr_cyc.size() >= base + 2) begin
            vectors++;
            if (wr_cyc[base+1] - wr_cyc[base] !== 8) begin
                miscompares++;
                $display("FAIL cc0_period: got %0d required 8", wr_cyc[base+1] - wr_cyc[base]);
            end
        end
    endtask

    task automatic test_backpressure();
        int base;
        base = wr_cnt;
        fifo_full = 1'b1;
        start(2, 3);
        steps(16);
        vectors++;
        if (stall_count !== 32'd7 || wr_cnt - base !== 0) begin
            miscompares++;
            $display("FAIL stall_hold: got stall=%0d writes=%0d required 7 0", stall_count, wr_cnt - base);
        end
        fifo_full = 1'b0;
        step();
        vectors++;
        if (wr_cnt - base !== 1) begin
            miscompares++;
            $display("FAIL stall_release_write: got %0d required 1", wr_cnt - base);
        end
        wait_wr(base + 2, 60);
        step();
        vectors++;
        if (stall_count !== 32'd7 || done !== 1'b1 || wr_cnt - base !== 2) begin
            miscompares++;
            $display("FAIL stall_final: got stall=%0d done=%b writes=%0d required 7 1 2",
                     stall_count, done, wr_cnt - base);
        end
        vectors++;
        if (viol !== 0) begin
            miscompares++;
            $display("FAIL write_while_full: got %0d required 0", viol);
        end
    endtask

    task automatic test_stop();
        int base, be;
        base = wr_cnt; be = en_cnt;
        start(5, 10);
        steps(39);
        stop = 1'b1;
        #1;
        vectors++;
        if (ro_en !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL stop_collect_ro_en: got ro_en=%b busy=%b required 0 1", ro_en, busy);
        end
        step();
        stop = 1'b0;
        vectors++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL stop_collect_done: got done=%b busy=%b required 1 0", done, busy);
        end
        steps(3);
        vectors++;
        if (wr_cnt - base !== 2 || en_cnt - be !== 24) begin
            miscompares++;
            $display("FAIL stop_collect_counts: got writes=%0d en=%0d required 2 24", wr_cnt - base, en_cnt - be);
        end
        base = wr_cnt;
        start(1, 1);
        steps(7);
        vectors++;
        if (fifo_wr_en !== 1'b1) begin
            miscompares++;
            $display("FAIL stop_push_pre: got wr_en=%b required 1", fifo_wr_en);
        end
        stop = 1'b1;
        #1;
        vectors++;
        if (fifo_wr_en !== 1'b0) begin
            miscompares++;
            $display("FAIL stop_push_priority: got wr_en=%b required 0", fifo_wr_en);
        end
        step();
        stop = 1'b0;
        steps(2);
        vectors++;
        if (done !== 1'b1 || wr_cnt - base !== 0) begin
            miscompares++;
            $display("FAIL stop_push_result: got done=%b writes=%0d required 1 0", done, wr_cnt - base);
        end
    endtask

    task automatic test_reset_mid_run();
        int base;
        fifo_full = 1'b1;
        start(1, 1);
        steps(9);
        vectors++;
        if (stall_count !== 32'd2) begin
            miscompares++;
            $display("FAIL rstmid_stall_pre: got %0d required 2", stall_count);
        end
        fifo_full = 1'b0;
        #1;
        vectors++;
        if (fifo_wr_en !== 1'b1) begin
            miscompares++;
            $display("FAIL rstmid_wr_en_pre: got %b required 1", fifo_wr_en);
        end
        rst = 1'b1;
        #1;
        vectors++;
        if (fifo_wr_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || stall_count !== 32'd0) begin
            miscompares++;
            $display("FAIL rstmid_async: got wr_en=%b busy=%b done=%b stall=%0d required 0 0 0 0",
                     fifo_wr_en, busy, done, stall_count);
        end
        step();
        rst = 1'b0;
        step();
        base = wr_cnt;
        start(1, 1);
        vectors++;
        if (busy !== 1'b1 || stall_count !== 32'd0) begin
            miscompares++;
            $display("FAIL rstmid_restart: got busy=%b stall=%0d required 1 0", busy, stall_count);
        end
        wait_wr(base + 1, 40);
        vectors++;
        if (done !== 1'b1 || stall_count !== 32'd0) begin
            miscompares++;
            $display("FAIL rstmid_clean_run: got done=%b stall=%0d required 1 0", done, stall_count);
        end
    endtask

    task automatic test_clamp();
        logic [21:0] vin [4];
        logic [19:0] vexp [4];
        int k;
        vin[0] = 22'h3FFFFF; vexp[0] = 20'hFFFFF;
        vin[1] = 22'h0FFFFF; vexp[1] = 20'hFFFFF;
        vin[2] = 22'h100000; vexp[2] = 20'hFFFFF;
        vin[3] = 22'h00ABCD; vexp[3] = 20'h0ABCD;
        sum2 = vin[0];
        go2 = 1'b1; ns2 = 4; cc2 = 1;
        step();
        go2 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sum2 = vin[i];
            k = 0;
            while (wr_en2 !== 1'b1 && k < 20) begin
                step();
                k++;
            end
            vectors++;
            if (data2 !== vexp[i] || wr_en2 !== 1'b1) begin
                miscompares++;
                $display("FAIL clamp[%0d]: got wr_en=%b data=%h required 1 %h", i, wr_en2, data2, vexp[i]);
            end
            step();
        end
        step();
        vectors++;
        if (done2 !== 1'b1) begin
            miscompares++;
            $display("FAIL clamp_done: got %b required 1", done2);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_samples();
        test_cc_zero();
        test_backpressure();
        test_stop();
        test_reset_mid_run();
        test_clamp();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
